// File: rtl/vga_pkg.sv
// Shared constants, state encoding and command record for the VGA pixel pipeline.
// The on_screen helper is only referenced when RECT_CLIP_EN is defined.
package vga_pkg;

  localparam int H_RES = 640;
  localparam int V_RES = 480;
  localparam int X_W   = 10;
  localparam int Y_W   = 9;
  localparam int C_W   = 24;

  localparam logic [X_W:0] H_LIM = (X_W+1)'(H_RES);
  localparam logic [Y_W:0] V_LIM = (Y_W+1)'(V_RES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [X_W-1:0] w;
    logic [Y_W-1:0] h;
    logic [C_W-1:0] color;
  } rect_cmd_t;

  // Sums carry one extra bit so coordinates past the edge are not mistaken for wrapped ones.
  function automatic logic on_screen(input logic [X_W:0] sx, input logic [Y_W:0] sy);
    return (sx < H_LIM) && (sy < V_LIM);
  endfunction

endpackage

// File: rtl/xy_scan_counter.sv
// Two-dimensional raster counter: column is the inner loop, row the outer loop.
// Exposes the next position combinationally so the top can register pixel outputs in step.
module xy_scan_counter
  import vga_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_clear,
  input  logic           i_advance,
  input  logic [X_W-1:0] i_w,
  input  logic [Y_W-1:0] i_h,
  output logic [X_W-1:0] o_next_col,
  output logic [Y_W-1:0] o_next_row,
  output logic           o_last
);

  logic [X_W-1:0] r_col;
  logic [Y_W-1:0] r_row;
  logic           w_col_wrap;
  logic           w_row_end;

  assign w_col_wrap = (r_col == (i_w - X_W'(1)));
  assign w_row_end  = (r_row == (i_h - Y_W'(1)));
  assign o_last     = w_col_wrap && w_row_end;

  always_comb begin
    o_next_col = r_col + X_W'(1);
    o_next_row = r_row;
    if (w_col_wrap) begin
      o_next_col = '0;
      o_next_row = r_row + Y_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_clear) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_advance) begin
      r_col <= o_next_col;
      r_row <= o_next_row;
    end
  end

endmodule

// File: rtl/rect_fill_engine.sv
// Rectangle-fill engine: one command in, a raster sweep of pixel writes out, one per cycle.
// Define RECT_CLIP_EN to suppress plot for pixels outside H_RES x V_RES; otherwise coordinates wrap.
module rect_fill_engine
  import vga_pkg::*;
(
  input  logic           CLOCK_50,
  input  logic           resetn,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [X_W-1:0] cmd_x,
  input  logic [Y_W-1:0] cmd_y,
  input  logic [X_W-1:0] cmd_w,
  input  logic [Y_W-1:0] cmd_h,
  input  logic [C_W-1:0] cmd_color,
  input  logic           stall,
  output logic           busy,
  output logic           done,
  output logic [X_W-1:0] VGA_X,
  output logic [Y_W-1:0] VGA_Y,
  output logic [C_W-1:0] VGA_COLOR,
  output logic           plot
);

  state_t         r_state;
  rect_cmd_t      r_cmd;
  logic [X_W-1:0] r_vga_x;
  logic [Y_W-1:0] r_vga_y;
  logic           r_plot;
  logic           r_done;
  logic           r_busy;

  logic           w_accept;
  logic           w_advance;
  logic           w_empty;
  logic           w_last;
  logic [X_W-1:0] w_next_col;
  logic [Y_W-1:0] w_next_row;
  logic [X_W-1:0] w_pix_x;
  logic [Y_W-1:0] w_pix_y;
  logic           w_next_plot;
  logic           w_first_plot;

  assign cmd_ready = (r_state == IDLE);
  assign w_accept  = cmd_valid && cmd_ready;
  assign w_advance = (r_state == DRAW) && !stall;
  assign w_empty   = (cmd_w == '0) || (cmd_h == '0);

  xy_scan_counter u_scan (
    .clk        (CLOCK_50),
    .rst_n      (resetn),
    .i_clear    (w_accept),
    .i_advance  (w_advance),
    .i_w        (r_cmd.w),
    .i_h        (r_cmd.h),
    .o_next_col (w_next_col),
    .o_next_row (w_next_row),
    .o_last     (w_last)
  );

`ifdef RECT_CLIP_EN
  logic [X_W:0] w_sum_x;
  logic [Y_W:0] w_sum_y;

  assign w_sum_x      = {1'b0, r_cmd.x} + {1'b0, w_next_col};
  assign w_sum_y      = {1'b0, r_cmd.y} + {1'b0, w_next_row};
  assign w_pix_x      = w_sum_x[X_W-1:0];
  assign w_pix_y      = w_sum_y[Y_W-1:0];
  assign w_next_plot  = on_screen(w_sum_x, w_sum_y);
  assign w_first_plot = on_screen({1'b0, cmd_x}, {1'b0, cmd_y});
`else
  assign w_pix_x      = r_cmd.x + w_next_col;
  assign w_pix_y      = r_cmd.y + w_next_row;
  assign w_next_plot  = 1'b1;
  assign w_first_plot = 1'b1;
`endif

  // Outputs are loaded with the pixel about to be shown, so the first pixel appears the cycle after accept.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_cmd   <= '0;
      r_vga_x <= '0;
      r_vga_y <= '0;
      r_plot  <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (cmd_valid) begin
            r_cmd.x     <= cmd_x;
            r_cmd.y     <= cmd_y;
            r_cmd.w     <= cmd_w;
            r_cmd.h     <= cmd_h;
            r_cmd.color <= cmd_color;
            r_busy      <= 1'b1;
            if (w_empty) begin
              r_state <= DONE;
              r_done  <= 1'b1;
              r_plot  <= 1'b0;
            end else begin
              r_state <= DRAW;
              r_vga_x <= cmd_x;
              r_vga_y <= cmd_y;
              r_plot  <= w_first_plot;
            end
          end
        end
        DRAW: begin
          if (!stall) begin
            if (w_last) begin
              r_state <= DONE;
              r_done  <= 1'b1;
              r_plot  <= 1'b0;
            end else begin
              r_vga_x <= w_pix_x;
              r_vga_y <= w_pix_y;
              r_plot  <= w_next_plot;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign VGA_X     = r_vga_x;
  assign VGA_Y     = r_vga_y;
  assign VGA_COLOR = r_cmd.color;
  assign plot      = r_plot;
  assign done      = r_done;
  assign busy      = r_busy;

endmodule

// File: tb/tb_rect_fill_engine.sv
// Directed bench for rect_fill_engine: raster order, stall, degenerate, clipping/wrap, held valid, reset.
// Expectations for the edge-of-screen case follow RECT_CLIP_EN.
module tb_rect_fill_engine;

  logic        CLOCK_50 = 1'b0;
  logic        resetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  cmd_x;
  logic [8:0]  cmd_y;
  logic [9:0]  cmd_w;
  logic [8:0]  cmd_h;
  logic [23:0] cmd_color;
  logic        stall;
  logic        busy;
  logic        done;
  logic [9:0]  VGA_X;
  logic [8:0]  VGA_Y;
  logic [23:0] VGA_COLOR;
  logic        plot;

  int checks = 0;
  int errors = 0;

  int          plotCnt;
  int          doneCnt;
  int          doneCyc;
  int          acceptCyc;
  logic [9:0]  pX [0:31];
  logic [8:0]  pY [0:31];
  logic [23:0] pC [0:31];
  int          pCyc [0:31];
  bit          rdyAt [0:31];
  bit          busyAt [0:31];
  int          expX [0:7];
  int          expY [0:7];

  rect_fill_engine dut (
    .CLOCK_50  (CLOCK_50),
    .resetn    (resetn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_x     (cmd_x),
    .cmd_y     (cmd_y),
    .cmd_w     (cmd_w),
    .cmd_h     (cmd_h),
    .cmd_color (cmd_color),
    .stall     (stall),
    .busy      (busy),
    .done      (done),
    .VGA_X     (VGA_X),
    .VGA_Y     (VGA_Y),
    .VGA_COLOR (VGA_COLOR),
    .plot      (plot)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Called at a negedge; leaves the bench at the negedge of the first cycle after accept.
  task automatic applyStimulus(input int x, input int y, input int w, input int h,
                               input logic [23:0] c, input bit holdValid);
    checkOutput("ready_before_cmd", cmd_ready, 1);
    cmd_x     = 10'(x);
    cmd_y     = 9'(y);
    cmd_w     = 10'(w);
    cmd_h     = 9'(h);
    cmd_color = c;
    cmd_valid = 1'b1;
    @(negedge CLOCK_50);
    if (!holdValid) cmd_valid = 1'b0;
  endtask

  task automatic watch(input int n, input int stallFrom, input int stallLen, input int resetAt);
    bit dropNext = 1'b0;
    plotCnt   = 0;
    doneCnt   = 0;
    doneCyc   = -1;
    acceptCyc = -1;
    for (int cyc = 1; cyc <= n && cyc < 32; cyc++) begin
      if (!resetn) resetn = 1'b1;
      rdyAt[cyc]  = cmd_ready;
      busyAt[cyc] = busy;
      if (plot && plotCnt < 32) begin
        pX[plotCnt]   = VGA_X;
        pY[plotCnt]   = VGA_Y;
        pC[plotCnt]   = VGA_COLOR;
        pCyc[plotCnt] = cyc;
        plotCnt++;
      end
      if (done) begin
        doneCnt++;
        if (doneCyc < 0) doneCyc = cyc;
      end
      if (dropNext) begin
        cmd_valid = 1'b0;
        dropNext  = 1'b0;
      end
      if (cmd_valid && cmd_ready) begin
        acceptCyc = cyc;
        dropNext  = 1'b1;
      end
      stall = (cyc >= stallFrom) && (cyc < stallFrom + stallLen);
      if (cyc == resetAt) begin
        resetn = 1'b0;
        #1;
        checkOutput("rst_mid_plot", plot, 0);
        checkOutput("rst_mid_x", VGA_X, 0);
        checkOutput("rst_mid_y", VGA_Y, 0);
        checkOutput("rst_mid_color", VGA_COLOR, 0);
        checkOutput("rst_mid_done", done, 0);
        checkOutput("rst_mid_busy", busy, 0);
        checkOutput("rst_mid_ready", cmd_ready, 1);
      end
      @(negedge CLOCK_50);
    end
    stall = 1'b0;
  endtask

  task automatic checkPlots(input string tag, input int expCount, input int nCompare,
                            input logic [23:0] color);
    checkOutput({tag, "_count"}, plotCnt, expCount);
    for (int i = 0; i < nCompare && i < plotCnt; i++) begin
      checkOutput($sformatf("%s_x%0d", tag, i), pX[i], expX[i]);
      checkOutput($sformatf("%s_y%0d", tag, i), pY[i], expY[i]);
      checkOutput($sformatf("%s_c%0d", tag, i), pC[i], color);
    end
  endtask

  initial begin
    resetn    = 1'b0;
    cmd_valid = 1'b0;
    cmd_x     = '0;
    cmd_y     = '0;
    cmd_w     = '0;
    cmd_h     = '0;
    cmd_color = '0;
    stall     = 1'b0;
    #12;
    checkOutput("rst_x", VGA_X, 0);
    checkOutput("rst_y", VGA_Y, 0);
    checkOutput("rst_color", VGA_COLOR, 0);
    checkOutput("rst_plot", plot, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_ready", cmd_ready, 1);
    @(negedge CLOCK_50);
    resetn = 1'b1;
    @(negedge CLOCK_50);

    // 3x2 rectangle, no stall
    applyStimulus(10, 20, 3, 2, 24'hFF0000, 1'b0);
    watch(12, 0, 0, 0);
    expX = '{10, 11, 12, 10, 11, 12, 0, 0};
    expY = '{20, 20, 20, 21, 21, 21, 0, 0};
    checkPlots("basic", 6, 6, 24'hFF0000);
    checkOutput("basic_first_cyc", pCyc[0], 1);
    checkOutput("basic_last_cyc", pCyc[5], 6);
    checkOutput("basic_done_cyc", doneCyc, 7);
    checkOutput("basic_done_cnt", doneCnt, 1);
    checkOutput("basic_busy_c1", busyAt[1], 1);
    checkOutput("basic_busy_c7", busyAt[7], 1);
    checkOutput("basic_busy_c8", busyAt[8], 0);
    checkOutput("basic_ready_c7", rdyAt[7], 0);
    checkOutput("basic_ready_c8", rdyAt[8], 1);

    // Degenerate width
    applyStimulus(50, 50, 0, 5, 24'hABCDEF, 1'b0);
    watch(6, 0, 0, 0);
    checkOutput("degen_plots", plotCnt, 0);
    checkOutput("degen_done_cyc", doneCyc, 1);
    checkOutput("degen_done_cnt", doneCnt, 1);
    checkOutput("degen_busy_c1", busyAt[1], 1);
    checkOutput("degen_ready_c1", rdyAt[1], 0);
    checkOutput("degen_ready_c2", rdyAt[2], 1);

    // Stall for two cycles while (11,20) is shown
    applyStimulus(10, 20, 3, 2, 24'hFF0000, 1'b0);
    watch(14, 2, 2, 0);
    expX = '{10, 11, 11, 11, 12, 10, 11, 12};
    expY = '{20, 20, 20, 20, 20, 21, 21, 21};
    checkPlots("stall", 8, 8, 24'hFF0000);
    checkOutput("stall_last_cyc", pCyc[7], 8);
    checkOutput("stall_done_cyc", doneCyc, 9);
    checkOutput("stall_done_cnt", doneCnt, 1);

    // Right screen edge
    applyStimulus(638, 0, 4, 1, 24'h00FFFF, 1'b0);
    watch(8, 0, 0, 0);
`ifdef RECT_CLIP_EN
    expX = '{638, 639, 0, 0, 0, 0, 0, 0};
    expY = '{0, 0, 0, 0, 0, 0, 0, 0};
    checkPlots("edge", 2, 2, 24'h00FFFF);
`else
    expX = '{638, 639, 640, 641, 0, 0, 0, 0};
    expY = '{0, 0, 0, 0, 0, 0, 0, 0};
    checkPlots("edge", 4, 4, 24'h00FFFF);
`endif
    checkOutput("edge_done_cyc", doneCyc, 5);

    // cmd_valid held through DRAW: the second command waits for IDLE
    applyStimulus(10, 20, 3, 2, 24'h0000FF, 1'b1);
    cmd_x     = 10'd100;
    cmd_y     = 9'd100;
    cmd_w     = 10'd1;
    cmd_h     = 9'd1;
    cmd_color = 24'h00FF00;
    watch(14, 0, 0, 0);
    expX = '{10, 11, 12, 10, 11, 12, 0, 0};
    expY = '{20, 20, 20, 21, 21, 21, 0, 0};
    checkPlots("hold", 7, 6, 24'h0000FF);
    checkOutput("hold_accept_cyc", acceptCyc, 8);
    checkOutput("hold_p2_x", pX[6], 100);
    checkOutput("hold_p2_y", pY[6], 100);
    checkOutput("hold_p2_color", pC[6], 24'h00FF00);
    checkOutput("hold_p2_cyc", pCyc[6], 9);
    checkOutput("hold_done_cyc", doneCyc, 7);
    checkOutput("hold_done_cnt", doneCnt, 2);

    // Reset while the third pixel of a 10x10 is shown
    applyStimulus(0, 0, 10, 10, 24'h123456, 1'b0);
    watch(14, 0, 0, 3);
    checkOutput("abort_plots", plotCnt, 3);
    checkOutput("abort_p3_x", pX[2], 2);
    checkOutput("abort_done_cnt", doneCnt, 0);
    checkOutput("abort_ready_c10", rdyAt[10], 1);
    checkOutput("abort_busy_c10", busyAt[10], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
